// File: rtl/iir_tap_sequencer.sv
// Direct-Form-I IIR tap sequencer.
// Keeps the x/y delay lines and the coefficient RAM. Each cycle in MAC it
// presents one coefficient/data pair, in sign-magnitude form, to an external
// combinational Q15.16 multiplier. It accumulates the returned product and
// emits a saturated y sample under a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for x[n]; coefficient writes are accepted here only
// S_MAC  | one tap per cycle: b0..bN on x0..xN, then fb1..fbN on y1..yN
// S_OUT  | y[n] held on out_data until the consumer takes it
module iir_tap_sequencer #(
  parameter int ORDER = 2,
  parameter int ACC_W = 40,
  localparam int TAPS = 2*ORDER + 1,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [31:0]   coef_data,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [14:0]   mul_a,
  output logic [15:0]   mul_b,
  output logic          mul_sign_a,
  output logic [14:0]   mul_c,
  output logic [15:0]   mul_d,
  output logic          mul_sign_c,
  input  logic [31:0]   mul_p
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]           tap;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [31:0]             coef_mem [TAPS];
  logic [31:0]             x_line   [ORDER+1];
  logic [31:0]             y_line   [1:ORDER];

  logic        tap_last;
  logic        ovf_pos;
  logic        ovf_neg;
  logic [31:0] acc_sat;
  logic [31:0] coef_sel;
  logic [31:0] data_sel;
  logic [31:0] coef_sm;
  logic [31:0] data_sm;

  // Two's complement to {sign, 31-bit magnitude}; the most negative value
  // has no positive twin, so its magnitude is pinned to full scale.
  function automatic logic [31:0] to_sm(input logic [31:0] v);
    logic [31:0] mag;
    mag = v;
    if (v[31]) begin
      if (v == 32'h8000_0000) mag = 32'h7FFF_FFFF;
      else                    mag = -v;
    end
    return {v[31], mag[30:0]};
  endfunction

  assign tap_last = (tap == AW'(TAPS-1));

  // Running sum with the current product, and its 32-bit saturated form.
  always_comb begin
    acc_sum = acc + {{(ACC_W-32){mul_p[31]}}, mul_p};
    ovf_pos = !acc_sum[ACC_W-1] && (|acc_sum[ACC_W-2:31]);
    ovf_neg =  acc_sum[ACC_W-1] && !(&acc_sum[ACC_W-2:31]);
    if (ovf_pos)      acc_sat = 32'h7FFF_FFFF;
    else if (ovf_neg) acc_sat = 32'h8000_0000;
    else              acc_sat = acc_sum[31:0];
  end

  // Operand select: coefficient by tap, data from x line then y line.
  always_comb begin
    coef_sel = '0;
    data_sel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (tap == AW'(i)) coef_sel = coef_mem[i];
    end
    for (int i = 0; i <= ORDER; i++) begin
      if (tap == AW'(i)) data_sel = x_line[i];
    end
    for (int j = 1; j <= ORDER; j++) begin
      if (tap == AW'(ORDER + j)) data_sel = y_line[j];
    end
    coef_sm = to_sm(coef_sel);
    data_sm = to_sm(data_sel);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_MAC;
      S_MAC:   if (tap_last)  state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; multiplier operands are quiet outside MAC.
  always_comb begin
    in_ready   = (state == S_IDLE);
    mul_a      = '0;
    mul_b      = '0;
    mul_sign_a = 1'b0;
    mul_c      = '0;
    mul_d      = '0;
    mul_sign_c = 1'b0;
    if (state == S_MAC) begin
      mul_sign_a = coef_sm[31];
      mul_a      = coef_sm[30:16];
      mul_b      = coef_sm[15:0];
      mul_sign_c = data_sm[31];
      mul_c      = data_sm[30:16];
      mul_d      = data_sm[15:0];
    end
  end

  // Datapath: coefficient RAM, delay lines, accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++)   coef_mem[i] <= '0;
      for (int i = 0; i <= ORDER; i++) x_line[i]   <= '0;
      for (int j = 1; j <= ORDER; j++) y_line[j]   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Write lands in the same edge as an accept, so this sample uses it.
          if (coef_we) begin
            for (int i = 0; i < TAPS; i++) begin
              if (coef_addr == AW'(i)) coef_mem[i] <= coef_data;
            end
          end
          if (in_valid) begin
            x_line[0] <= in_data;
            for (int i = 1; i <= ORDER; i++) x_line[i] <= x_line[i-1];
            acc <= '0;
            tap <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          tap <= tap + 1'b1;
          if (tap_last) begin
            out_data  <= acc_sat;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            y_line[1] <= out_data;
            for (int j = 2; j <= ORDER; j++) y_line[j] <= y_line[j-1];
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_tap_sequencer.sv
// Bench for iir_tap_sequencer: a transaction-level filter model plus an
// external multiplier model, compared against the DUT on every cycle.
module tb_iir_tap_sequencer;
  localparam int N    = 2;
  localparam int TAPS = 2*N + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_sign_a;
  logic [14:0] mul_c;
  logic [15:0] mul_d;
  logic        mul_sign_c;
  logic [31:0] mul_p;

  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;

  int n_tests = 0;
  int n_fail  = 0;

  iir_tap_sequencer #(.ORDER(N), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_sign_a(mul_sign_a),
    .mul_c(mul_c), .mul_d(mul_d), .mul_sign_c(mul_sign_c),
    .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  // ---------------- arithmetic helpers ----------------
  function automatic logic [30:0] mag_of(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    return s[30:0];
  endfunction

  function automatic logic [31:0] mul_sm(input logic neg, input logic [30:0] ma, input logic [30:0] mc);
    longint p;
    p = (longint'(ma) * longint'(mc)) >>> 16;
    if (neg) p = -p;
    return p[31:0];
  endfunction

  function automatic logic [31:0] mulq(input logic [31:0] c, input logic [31:0] d);
    return mul_sm(c[31] ^ d[31], mag_of(c), mag_of(d));
  endfunction

  function automatic logic [31:0] sat32(input longint s);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // External multiplier: Q15.16 sign-magnitude product, or a forced value.
  assign mul_p = force_en ? force_val
               : mul_sm(mul_sign_a ^ mul_sign_c, {mul_a, mul_b}, {mul_c, mul_d});

  // ---------------- reference model ----------------
  logic [31:0] m_coef [TAPS];
  logic [31:0] m_x    [N+1];
  logic [31:0] m_y    [1:N];
  int          ph = -1;      // -1: no tap in flight, else tap index this cycle
  bit          m_outv = 1'b0;
  logic [31:0] m_outd = '0;
  logic [31:0] m_pend = '0;

  function automatic logic [31:0] data_at(input int i);
    if (i <= N) return m_x[i];
    return m_y[i-N];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    longint s;
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) m_coef[i] = '0;
      for (int i = 0; i <= N; i++)   m_x[i] = '0;
      for (int j = 1; j <= N; j++)   m_y[j] = '0;
      ph = -1; m_outv = 1'b0; m_outd = '0; m_pend = '0;
    end else if (ph < 0 && !m_outv) begin
      if (coef_we && int'(coef_addr) < TAPS) m_coef[coef_addr] = coef_data;
      if (in_valid) begin
        for (int i = N; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = in_data;
        s = 0;
        for (int i = 0; i < TAPS; i++)
          s += longint'($signed(force_en ? force_val : mulq(m_coef[i], data_at(i))));
        m_pend = sat32(s);
        ph = 0;
      end
    end else if (ph >= 0) begin
      if (ph == 2*N) begin
        ph = -1; m_outv = 1'b1; m_outd = m_pend;
      end else ph++;
    end else if (out_ready) begin
      for (int j = N; j > 1; j--) m_y[j] = m_y[j-1];
      m_y[1] = m_outd;
      m_outv = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] c, d;
    logic [30:0] mc, md;
    chk("in_ready", 32'(in_ready), 32'(ph < 0 && !m_outv));
    chk("out_valid", 32'(out_valid), 32'(m_outv));
    if (m_outv) chk("out_data", out_data, m_outd);
    if (ph >= 0) begin
      c = m_coef[ph]; d = data_at(ph);
      mc = mag_of(c); md = mag_of(d);
      chk("mul_sign_a", 32'(mul_sign_a), 32'(c[31]));
      chk("mul_a", 32'(mul_a), 32'(mc[30:16]));
      chk("mul_b", 32'(mul_b), 32'(mc[15:0]));
      chk("mul_sign_c", 32'(mul_sign_c), 32'(d[31]));
      chk("mul_c", 32'(mul_c), 32'(md[30:16]));
      chk("mul_d", 32'(mul_d), 32'(md[15:0]));
    end else begin
      chk("mul_idle", {mul_sign_a, mul_a, mul_sign_c, mul_c}, 32'h0);
      chk("mul_idle_frac", {mul_b, mul_d}, 32'h0);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_reset();
    coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    coef_we = 1'b1; coef_addr = a; coef_data = v;
    @(posedge clk); #1 coef_we = 1'b0;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = x;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) timeout("send");
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (as 1) until out_valid rises.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    if (!out_valid) timeout("wait_out");
  endtask

  task automatic take(output logic [31:0] y);
    bit ok;
    ok = 1'b0;
    y = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; y = out_data; end
    end
    if (!ok) timeout("take");
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = $urandom;
      default: begin
        v = 32'($urandom_range(0, 32'h3FFFF));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  // ---------------- directed and random sequence ----------------
  initial begin
    int lat;
    logic [31:0] y;
    logic [31:0] fb_exp [3];
    fb_exp[0] = 32'h0001_0000; fb_exp[1] = 32'h0000_8000; fb_exp[2] = 32'h0000_4000;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    @(posedge clk); #1;

    // Unity gain and latency
    wr(3'd0, 32'h0001_0000);
    send(32'h0003_0000);
    wait_out(lat);
    chk("unity_latency", 32'(lat), 32'd6);
    take(y);
    chk("unity_out", y, 32'h0003_0000);

    // Negative coefficient, sign-magnitude operands at tap 0
    do_reset();
    wr(3'd0, 32'hFFFF_8000);
    send(32'h0002_0000);
    chk("neg_sign_a", 32'(mul_sign_a), 32'h1);
    chk("neg_mul_a", 32'(mul_a), 32'h0);
    chk("neg_mul_b", 32'(mul_b), 32'h8000);
    chk("neg_mul_c", 32'(mul_c), 32'h2);
    wait_out(lat);
    take(y);
    chk("neg_out", y, 32'hFFFF_0000);

    // Feedback impulse response
    do_reset();
    wr(3'd0, 32'h0001_0000);
    wr(3'd3, 32'h0000_8000);
    for (int k = 0; k < 3; k++) begin
      send(k == 0 ? 32'h0001_0000 : 32'h0);
      wait_out(lat);
      take(y);
      chk($sformatf("feedback_y%0d", k), y, fb_exp[k]);
    end

    // Saturation both ways
    force_en = 1'b1; force_val = 32'h7FFF_FFFF;
    send(32'h0000_1234);
    wait_out(lat);
    take(y);
    chk("sat_pos", y, 32'h7FFF_FFFF);
    force_val = 32'h8000_0000;
    send(32'h0000_1234);
    wait_out(lat);
    take(y);
    chk("sat_neg", y, 32'h8000_0000);
    force_en = 1'b0; force_val = '0;

    // Backpressure: output held, writes ignored, y line shifts once
    do_reset();
    wr(3'd0, 32'h0001_0000);
    wr(3'd3, 32'h0001_0000);
    wr(3'd4, 32'h0001_0000);
    send(32'h0005_0000);
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 32'h0002_0000;
      @(negedge clk);
      chk("bp_out_data", out_data, 32'h0005_0000);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
    take(y);
    chk("bp_out", y, 32'h0005_0000);
    send(32'h0001_0000);
    wait_out(lat);
    take(y);
    chk("bp_next", y, 32'h0006_0000);

    // Reset in the middle of MAC
    send(32'h0001_0000);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_mul", {mul_sign_a, mul_a, mul_sign_c, mul_c}, 32'h0);
    chk("midrst_mul_frac", {mul_b, mul_d}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < TAPS; i++) wr(3'(i), rnd_val());
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rnd_val();
      out_ready = ($urandom_range(0, 3) != 0);
      coef_we   = ($urandom_range(0, 7) == 0);
      coef_addr = 3'($urandom_range(0, 7));
      coef_data = rnd_val();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
